// File: rtl/sub_div_seq_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// master drives the request and operands; slave returns status and results.
interface sub_div_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/sub_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, reset (sync, active-high), bus (slave: start/operands in; busy/done/results out).
module sub_div_seq #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  sub_div_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH+1:0] w_bin;
  logic             w_keep;
  logic [WIDTH:0]   w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_last;

  // Partial remainder shifted left, pulling in the next dividend bit.
  assign w_a = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_b = {1'b0, r_d};

  // Ripple borrow chain: w_a - w_b over WIDTH+1 bits.
  assign w_bin[0] = 1'b0;

  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
    assign w_diff[gi] = w_a[gi] ^ w_b[gi] ^ w_bin[gi];
    assign w_bin[gi+1] = (~w_a[gi] & w_b[gi])
                       | (~(w_a[gi] ^ w_b[gi]) & w_bin[gi]);
  end

  // A set top bit would be shifted out above w_a, so the true value
  // would exceed D; subtraction is then always kept.
  assign w_keep  = ~w_bin[WIDTH+1] | r_r[WIDTH];
  assign w_r_nxt = w_keep ? w_diff : w_a;
  assign w_q_nxt = {r_q[WIDTH-2:0], w_keep};
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            if (bus.divisor != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_d     <= bus.divisor;
              r_q     <= bus.dividend;
              r_r     <= '0;
              r_cnt   <= '0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rem   <= bus.dividend;
              r_dbz   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_nxt;
            r_rem   <= w_r_nxt[WIDTH-1:0];
            r_dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_sub_div_seq.sv
// Self-checking bench for sub_div_seq with a queue of expected results.
// Drives and samples on the falling clock edge.
module tb_sub_div_seq;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  sub_div_seq_if #(.WIDTH(W)) bus ();

  sub_div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request for a single cycle and record what it must produce.
  task automatic issue(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = W'(a);
      e.dz = 1'b1;
    end else begin
      e.q  = W'(a / b);
      e.r  = W'(a % b);
      e.dz = 1'b0;
    end
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; counts cycles and busy samples on the way.
  task automatic wait_done(input int lim, output int cyc,
                           output int nbusy, output bit seen);
    cyc   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && cyc < lim) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.busy === 1'b1) nbusy++;
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    total++;
    if (bus.quotient !== '0) begin
      bad++;
      $display("FAIL reset_quot got=%0d want=0", bus.quotient);
    end
    total++;
    if (bus.remainder !== '0) begin
      bad++;
      $display("FAIL reset_rem got=%0d want=0", bus.remainder);
    end
    total++;
    if (bus.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int   va[4] = '{13, 15, 7, 15};
    int   vb[4] = '{3, 1, 9, 15};
    int   cyc;
    int   nb;
    bit   seen;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i]);
      wait_done(20, cyc, nb, seen);
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL basic_timeout %0d/%0d no done", va[i], vb[i]);
        sb.delete();
      end else begin
        e = sb.pop_front();
        total++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
          bad++;
          $display("FAIL basic %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                   va[i], vb[i], bus.quotient, bus.remainder,
                   bus.div_by_zero, e.q, e.r, e.dz);
        end
        total++;
        if (cyc != W || nb != W) begin
          bad++;
          $display("FAIL basic_latency got cyc=%0d busy=%0d want %0d/%0d",
                   cyc, nb, W, W);
        end
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL basic_busy_at_done got=%b want=0", bus.busy);
        end
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin
        bad++;
        $display("FAIL basic_pulse got done=%b want=0", bus.done);
      end
    end
  endtask

  task automatic test_div_zero();
    int   cyc;
    int   nb;
    bit   seen;
    exp_t e;
    issue(9, 0);
    wait_done(20, cyc, nb, seen);
    total++;
    if (!seen || cyc != 0) begin
      bad++;
      $display("FAIL dz_latency got seen=%b cyc=%0d want 1/0", seen, cyc);
    end
    if (seen) begin
      e = sb.pop_front();
      total++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
        bad++;
        $display("FAIL dz got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                 bus.quotient, bus.remainder, bus.div_by_zero,
                 e.q, e.r, e.dz);
      end
    end else begin
      sb.delete();
    end
    total++;
    if (bus.busy !== 1'b0 || nb != 0) begin
      bad++;
      $display("FAIL dz_busy got busy=%b n=%0d want 0", bus.busy, nb);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int   cyc;
    int   nb;
    int   extra;
    bit   seen;
    exp_t e;
    issue(13, 3);
    bus.start    = 1'b1;
    bus.dividend = W'(2);
    bus.divisor  = W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(20, cyc, nb, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ign_timeout no done");
      sb.delete();
    end else begin
      e = sb.pop_front();
      total++;
      if ({bus.quotient, bus.remainder} !== {e.q, e.r}) begin
        bad++;
        $display("FAIL ign_result got q=%0d r=%0d want q=%0d r=%0d",
                 bus.quotient, bus.remainder, e.q, e.r);
      end
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      @(negedge clk);
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ign_second got activity=%0d want=0", extra);
    end
    total++;
    if (bus.quotient !== W'(4) || bus.remainder !== W'(1)) begin
      bad++;
      $display("FAIL ign_hold got q=%0d r=%0d want q=4 r=1",
               bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_abort();
    int   cyc;
    int   nb;
    int   extra;
    bit   seen;
    exp_t e;
    issue(13, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    total++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder,
         bus.div_by_zero} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got b=%b d=%b q=%0d r=%0d z=%b want 0",
               bus.busy, bus.done, bus.quotient, bus.remainder,
               bus.div_by_zero);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      @(negedge clk);
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL abort_quiet got activity=%0d want=0", extra);
    end
    issue(6, 4);
    wait_done(20, cyc, nb, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL abort_timeout no done after restart");
      sb.delete();
    end else begin
      e = sb.pop_front();
      total++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
        bad++;
        $display("FAIL abort_restart got q=%0d r=%0d want q=%0d r=%0d",
                 bus.quotient, bus.remainder, e.q, e.r);
      end
    end
    @(negedge clk);
  endtask

  // Every dividend/divisor pair, new start exactly W+2 cycles apart.
  task automatic test_back_to_back();
    exp_t e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(a, b);
        repeat (W) @(negedge clk);
        total++;
        if (bus.done !== 1'b1) begin
          bad++;
          $display("FAIL b2b_done %0d/%0d got done=%b want=1",
                   a, b, bus.done);
          sb.delete();
        end else begin
          e = sb.pop_front();
          total++;
          if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
            bad++;
            $display("FAIL b2b %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     a, b, bus.quotient, bus.remainder,
                     bus.div_by_zero, e.q, e.r, e.dz);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
